// File: rtl/rate_tick_gen.sv
// rate_tick_gen: table-driven programmable tick generator with glitch-free rate changes
module rate_tick_gen #(
  parameter int CNT_W = 24,
  parameter int SEL_W = 3,
  parameter logic [CNT_W*(2**SEL_W)-1:0] RATE_TABLE =
    {24'd999, 24'd499, 24'd249, 24'd99, 24'd49, 24'd24, 24'd9, 24'd4},
  parameter int RESET_SEL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             mode,
  input  logic             start,
  input  logic             sel_load,
  input  logic [SEL_W-1:0] sel_in,
  output logic             tick,
  output logic [CNT_W-1:0] cnt,
  output logic [SEL_W-1:0] cur_sel,
  output logic [CNT_W-1:0] rate_tc,
  output logic             pending,
  output logic             busy
);
  logic             run, wrap, armed, armed_n;
  logic [SEL_W-1:0] pend_sel;
  assign rate_tc = RATE_TABLE[int'(cur_sel)*CNT_W +: CNT_W];
  always_comb begin
    run     = en & (~mode | armed);
    wrap    = run & (cnt == rate_tc);
    armed_n = en & mode & (start | (armed & ~wrap));
  end
  // rate changes while running wait for a wrap so every period completes at its own TC
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      tick     <= 1'b0;
      cur_sel  <= SEL_W'(RESET_SEL);
      pend_sel <= '0;
      pending  <= 1'b0;
      armed    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      cnt   <= (run & ~wrap) ? cnt + 1'b1 : '0;
      tick  <= wrap;
      armed <= armed_n;
      busy  <= en & (~mode | armed_n);
      if (run) begin
        if (wrap & pending) cur_sel <= pend_sel;
        if (sel_load) pend_sel <= sel_in;
        pending <= sel_load | (pending & ~wrap);
      end else begin
        cur_sel <= sel_load ? sel_in : pending ? pend_sel : cur_sel;
        pending <= 1'b0;
      end
    end
  end
endmodule

// File: doc/rate_tick_gen.md
Name: rate_tick_gen

Overview:
- Parametrised successor to the fixed 3-bit rate decoder: table-driven programmable tick generator.
- Maps a rate-select code to a terminal count from a parameter table and runs the divider counter itself.
- Emits one-cycle ticks in continuous or one-shot mode; rate changes apply glitch-free at period boundaries.
- Sits between the control register and the sampling/timing logic clocked from the 4 MHz base clock.

Parameters:
- CNT_W, 24, width of counter and terminal counts.
- SEL_W, 3, rate-select width; table holds 2**SEL_W entries.
- RATE_TABLE, {24'd999,24'd499,24'd249,24'd99,24'd49,24'd24,24'd9,24'd4}, packed CNT_W*2**SEL_W vector; entry i at bits [i*CNT_W +: CNT_W] is terminal count TC for code i.
- RESET_SEL, 0, rate code loaded at reset.

Ports:
- clk  in  1  base clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  counter enable; 0 holds the generator idle.
- mode  in  1  0 = continuous, 1 = one-shot.
- start  in  1  one-shot arm pulse; ignored when mode=0.
- sel_load  in  1  strobe: request rate change to sel_in.
- sel_in  in  SEL_W  requested rate code.
- tick  out  1  registered one-cycle period pulse.
- cnt  out  CNT_W  current counter value.
- cur_sel  out  SEL_W  rate code in effect.
- rate_tc  out  CNT_W  terminal count in effect, RATE_TABLE[cur_sel].
- pending  out  1  rate change requested, not yet applied.
- busy  out  1  counter running.

Behaviour:
- Reset (synchronous, priority over all else): cnt=0, tick=0, cur_sel=RESET_SEL, pend_sel=0, pending=0, running=0 (busy=0).
- running (busy) = en & (mode=0 | one-shot armed). Arming occurs at an edge with mode=1 and start=1, provided en=1.
- Edges with running=1:
  - cnt==rate_tc: cnt<=0, tick<=1 (wrap edge).
  - otherwise: cnt<=cnt+1, tick<=0.
  - Period is rate_tc+1 cycles. First tick follows rate_tc+1 enabled edges from cnt=0. Default code 0 (TC=4) gives a tick every 5 cycles.
- Edges with running=0: cnt<=0, tick<=0. Dropping en mid-period discards the partial count; there is no resume.
- One-shot:
  - At the wrap edge the arm clears, so exactly one tick is produced and busy falls in the tick cycle.
  - start while already armed is ignored; it does not restart the count.
  - start on the wrap edge re-arms, and the counter continues from 0.
- Rate change while running=1:
  - sel_load writes pend_sel<=sel_in and pending<=1.
  - At the next wrap edge, cur_sel<=pend_sel and pending<=0.
  - The new TC governs the period that starts after that tick; the current period always completes at the old TC.
- Rate change while running=0: sel_load applies immediately (cur_sel<=sel_in, pending stays 0). When the generator goes idle with a request still pending, the pending value is applied on the first idle edge.
- sel_load on a wrap edge:
  - The wrap applies the pend_sel held before the edge (if pending=1).
  - The new sel_in then loads into pend_sel with pending=1, and applies at the following wrap.
  - Consecutive sel_loads overwrite pend_sel; last one wins.
- TC=0 table entry: tick every cycle while running, cnt constant 0.
- Comparison is equality on CNT_W bits. cnt never exceeds rate_tc because rate_tc changes only at a wrap, when cnt=0.
- rate_tc is combinational from the cur_sel register (table lookup). All other outputs are registered.

Test Plan:
- Reset, en=1, mode=0, default table: tick high once every 5 cycles. cnt runs 0,1,2,3,4,0. cur_sel=0, rate_tc=4.
- Running on code 0, sel_load with sel_in=3 at cnt=2: pending=1; ticks at 5-cycle spacing until the next wrap. cur_sel=3, rate_tc=49, pending=0 in the tick cycle. Next tick 50 cycles later.
- sel_load sel_in=1 exactly on the wrap edge while pending holds 2: cur_sel=2 after this wrap. Next period 25 cycles, then cur_sel=1 and 10-cycle period.
- mode=1, en=1, code 1, one start pulse: single tick 10 cycles after start, busy falls, cnt stays 0. A second start while busy does not shift tick timing.
- en dropped at cnt=30 on code 3, then sel_load sel_in=0 while idle: cnt=0, tick=0, cur_sel=0 on the next edge with no pending. Re-enable: tick after 5 cycles.
- Assert reset mid-period with pending=1: all outputs reach reset values on the next edge. The pending request is discarded.
